// File: rtl/cpu.sv
// Single-cycle 16-bit Hack-style core holding the A, D and PC registers.
// ROM, RAM and memory-mapped I/O live outside and are reached via o_pc / o_addrM.
module cpu (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_instruct,
    input  logic [15:0] i_inM,
    output logic [15:0] o_pc,
    output logic [15:0] o_addrM,
    output logic [15:0] o_outM,
    output logic        o_writeM
);

    logic [15:0] r_a;
    logic [15:0] r_d;
    logic [15:0] r_pc;

    logic        w_isC;
    logic        w_selM;
    logic        w_zx, w_nx, w_zy, w_ny, w_f, w_no;
    logic        w_destA, w_destD, w_destM;
    logic        w_jlt, w_jeq, w_jgt;
    logic [15:0] w_x;
    logic [15:0] w_y;
    logic [15:0] w_aluOut;
    logic        w_zr;
    logic        w_ng;
    logic        w_jump;

    assign w_isC   = i_instruct[15];
    assign w_selM  = i_instruct[12];
    assign w_zx    = i_instruct[11];
    assign w_nx    = i_instruct[10];
    assign w_zy    = i_instruct[9];
    assign w_ny    = i_instruct[8];
    assign w_f     = i_instruct[7];
    assign w_no    = i_instruct[6];
    assign w_destA = i_instruct[5];
    assign w_destD = i_instruct[4];
    assign w_destM = i_instruct[3];
    assign w_jlt   = i_instruct[2];
    assign w_jeq   = i_instruct[1];
    assign w_jgt   = i_instruct[0];

    // The ALU decodes every instruction, even A-instructions, where its result is unused.
    always_comb begin
        w_x = w_zx ? 16'h0000 : r_d;
        if (w_nx) begin
            w_x = ~w_x;
        end
        w_y = w_zy ? 16'h0000 : (w_selM ? i_inM : r_a);
        if (w_ny) begin
            w_y = ~w_y;
        end
        w_aluOut = w_f ? (w_x + w_y) : (w_x & w_y);
        if (w_no) begin
            w_aluOut = ~w_aluOut;
        end
    end

    assign w_zr   = (w_aluOut == 16'h0000);
    assign w_ng   = w_aluOut[15];
    assign w_jump = w_isC & ((w_jlt & w_ng) | (w_jeq & w_zr) | (w_jgt & ~w_ng & ~w_zr));

    assign o_outM   = w_aluOut;
    assign o_writeM = i_rst_n & w_isC & w_destM;
    assign o_pc     = r_pc;
    assign o_addrM  = r_a;

    // A, D and PC all update from pre-edge values, so a jump always targets the old A.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a  <= 16'h0000;
            r_d  <= 16'h0000;
            r_pc <= 16'h0000;
        end else begin
            if (!w_isC) begin
                r_a <= i_instruct;
            end else if (w_destA) begin
                r_a <= w_aluOut;
            end
            if (w_isC && w_destD) begin
                r_d <= w_aluOut;
            end
            r_pc <= w_jump ? r_a : (r_pc + 16'h0001);
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed cases, random instructions against a
// behavioural model, and a division program running from a bench-side ROM/RAM.
module tb_cpu;

    localparam logic [6:0] C_ZERO = 7'b0101010;
    localparam logic [6:0] C_ONE  = 7'b0111111;
    localparam logic [6:0] C_D    = 7'b0001100;
    localparam logic [6:0] C_A    = 7'b0110000;
    localparam logic [6:0] C_M    = 7'b1110000;
    localparam logic [6:0] C_NEGM = 7'b1110011;
    localparam logic [6:0] C_MP1  = 7'b1110111;
    localparam logic [6:0] C_DP1  = 7'b0011111;
    localparam logic [6:0] C_DMM  = 7'b1010011;
    localparam logic [6:0] C_NEG1 = 7'b0111010;

    localparam logic [2:0] D_NULL = 3'b000;
    localparam logic [2:0] D_M    = 3'b001;
    localparam logic [2:0] D_D    = 3'b010;
    localparam logic [2:0] D_A    = 3'b100;

    localparam logic [2:0] J_NONE = 3'b000;
    localparam logic [2:0] J_JGT  = 3'b001;
    localparam logic [2:0] J_JEQ  = 3'b010;
    localparam logic [2:0] J_JGE  = 3'b011;
    localparam logic [2:0] J_JLT  = 3'b100;
    localparam logic [2:0] J_JLE  = 3'b110;
    localparam logic [2:0] J_JMP  = 3'b111;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruct;
    logic [15:0] inM;
    logic [15:0] pc;
    logic [15:0] addrM;
    logic [15:0] outM;
    logic        writeM;

    logic        useRom;
    logic [15:0] drvInstr;
    logic [15:0] drvInM;
    logic [15:0] rom [0:65535];
    logic [15:0] ram [0:65535];

    int checkCount;
    int passCount;
    int mA, mD, mPC;
    logic [15:0] sampledOut;
    logic        sampledWr;

    int romPtr;
    int lBzero, lBpos, lApos, lLoop, lDone, lAneg, lSign, lSignNeg, lPosQ, lNegQ, lEnd;

    logic [6:0]  tblComp [18];
    logic [15:0] tblExp  [18];

    cpu dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_instruct (instruct),
        .i_inM      (inM),
        .o_pc       (pc),
        .o_addrM    (addrM),
        .o_outM     (outM),
        .o_writeM   (writeM)
    );

    assign instruct = useRom ? rom[pc] : drvInstr;
    assign inM      = useRom ? ram[addrM] : drvInM;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The external data RAM, only live while the core runs from the ROM image.
    always @(posedge clk) begin
        if (useRom && writeM) begin
            ram[addrM] <= outM;
        end
    end

    function automatic logic [15:0] aI(input int v);
        logic [15:0] w;
        w = v[15:0];
        return {1'b0, w[14:0]};
    endfunction

    function automatic logic [15:0] cI(input logic [6:0] comp, input logic [2:0] dest, input logic [2:0] jmp);
        return {3'b111, comp, dest, jmp};
    endfunction

    // Reference ALU built from the arithmetic rules: negation is 65535 - v, sum is modulo 65536.
    function automatic int refAlu(input logic [15:0] instr, input int a, input int d, input int m);
        int x, y, r;
        x = instr[11] ? 0 : d;
        if (instr[10]) x = 65535 - x;
        y = instr[12] ? m : a;
        if (instr[9]) y = 0;
        if (instr[8]) y = 65535 - y;
        if (instr[7]) r = (x + y) % 65536;
        else          r = x & y;
        if (instr[6]) r = 65535 - r;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drives one instruction for one cycle, checks the combinational outputs, then the new state.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] m);
        int expOut, sv, nextA, nextD, nextPc;
        bit taken;
        @(negedge clk);
        drvInstr = instr;
        drvInM   = m;
        #1;
        expOut = refAlu(instr, mA, mD, int'(m));
        sampledOut = outM;
        sampledWr  = writeM;
        if (instr[15]) checkOutput("outM", outM, expOut);
        checkOutput("writeM", writeM, instr[15] & instr[3]);
        sv = (expOut >= 32768) ? expOut - 65536 : expOut;
        taken = instr[15] && ((instr[2] && sv < 0) || (instr[1] && sv == 0) || (instr[0] && sv > 0));
        nextPc = taken ? mA : (mPC + 1) % 65536;
        nextA  = !instr[15] ? int'(instr) : (instr[5] ? expOut : mA);
        nextD  = (instr[15] && instr[4]) ? expOut : mD;
        @(posedge clk);
        #1;
        mA = nextA;
        mD = nextD;
        mPC = nextPc;
        checkOutput("pc", pc, mPC);
        checkOutput("addrM", addrM, mA);
    endtask

    // Releases reset on a falling edge and checks that the first rising edge executes firstInstr at pc 0.
    task automatic releaseReset(input logic [15:0] firstInstr);
        @(negedge clk);
        rst_n    = 1'b1;
        drvInstr = firstInstr;
        @(posedge clk);
        #1;
        mA = int'(firstInstr);
        mD = 0;
        mPC = 1;
        checkOutput("rst_first_pc", pc, 16'h0001);
        checkOutput("rst_first_addrM", addrM, firstInstr);
    endtask

    task automatic emitA(input int v);
        rom[romPtr] = aI(v);
        romPtr++;
    endtask

    task automatic emitC(input logic [6:0] comp, input logic [2:0] dest, input logic [2:0] jmp);
        rom[romPtr] = cI(comp, dest, jmp);
        romPtr++;
    endtask

    // Euclidean division: RAM[2]=RAM[0]/RAM[1], RAM[3]=non-negative remainder; b==0 gives 0, 32767.
    task automatic buildDiv();
        romPtr = 0;
        emitA(1);  emitC(C_M, D_D, J_NONE); emitA(lBzero); emitC(C_D, D_NULL, J_JEQ);
        emitA(17); emitC(C_D, D_M, J_NONE); emitA(lBpos);  emitC(C_D, D_NULL, J_JGE);
        emitA(17); emitC(C_NEGM, D_M, J_NONE);
        lBpos = romPtr;
        emitA(0);  emitC(C_M, D_D, J_NONE); emitA(16); emitC(C_D, D_M, J_NONE);
        emitA(lApos); emitC(C_D, D_NULL, J_JGE);
        emitA(16); emitC(C_NEGM, D_M, J_NONE);
        lApos = romPtr;
        emitA(18); emitC(C_ZERO, D_M, J_NONE);
        lLoop = romPtr;
        emitA(16); emitC(C_M, D_D, J_NONE); emitA(17); emitC(C_DMM, D_D, J_NONE);
        emitA(lDone); emitC(C_D, D_NULL, J_JLT);
        emitA(16); emitC(C_D, D_M, J_NONE); emitA(18); emitC(C_MP1, D_M, J_NONE);
        emitA(lLoop); emitC(C_ZERO, D_NULL, J_JMP);
        lDone = romPtr;
        emitA(0);  emitC(C_M, D_D, J_NONE); emitA(lAneg); emitC(C_D, D_NULL, J_JLT);
        emitA(16); emitC(C_M, D_D, J_NONE); emitA(3); emitC(C_D, D_M, J_NONE);
        emitA(lSign); emitC(C_ZERO, D_NULL, J_JMP);
        lAneg = romPtr;
        emitA(16); emitC(C_M, D_D, J_NONE); emitA(3); emitC(C_D, D_M, J_NONE);
        emitA(lSignNeg); emitC(C_D, D_NULL, J_JEQ);
        emitA(17); emitC(C_M, D_D, J_NONE); emitA(16); emitC(C_DMM, D_D, J_NONE);
        emitA(3);  emitC(C_D, D_M, J_NONE);
        emitA(18); emitC(C_MP1, D_M, J_NONE);
        lSignNeg = romPtr;
        emitA(1);  emitC(C_M, D_D, J_NONE); emitA(lNegQ); emitC(C_D, D_NULL, J_JGT);
        emitA(lPosQ); emitC(C_ZERO, D_NULL, J_JMP);
        lSign = romPtr;
        emitA(1);  emitC(C_M, D_D, J_NONE); emitA(lNegQ); emitC(C_D, D_NULL, J_JLT);
        lPosQ = romPtr;
        emitA(18); emitC(C_M, D_D, J_NONE); emitA(2); emitC(C_D, D_M, J_NONE);
        emitA(lEnd); emitC(C_ZERO, D_NULL, J_JMP);
        lNegQ = romPtr;
        emitA(18); emitC(C_NEGM, D_D, J_NONE); emitA(2); emitC(C_D, D_M, J_NONE);
        emitA(lEnd); emitC(C_ZERO, D_NULL, J_JMP);
        lBzero = romPtr;
        emitA(2);  emitC(C_ZERO, D_M, J_NONE); emitA(32767); emitC(C_A, D_D, J_NONE);
        emitA(3);  emitC(C_D, D_M, J_NONE);
        lEnd = romPtr;
        emitA(lEnd); emitC(C_ZERO, D_NULL, J_JMP);
    endtask

    task automatic runDiv(input int a, input int b);
        int q, r, cycles;
        bit done;
        if (b == 0) begin
            q = 0;
            r = 32767;
        end else begin
            q = a / b;
            r = a % b;
            if (r < 0) begin
                r = r + ((b < 0) ? -b : b);
                q = (b > 0) ? q - 1 : q + 1;
            end
        end
        @(negedge clk);
        useRom = 1'b1;
        rst_n  = 1'b0;
        ram[0] = a[15:0];
        ram[1] = b[15:0];
        ram[2] = 16'hDEAD;
        ram[3] = 16'hBEEF;
        #1;
        rst_n = 1'b1;
        done = 1'b0;
        cycles = 0;
        while (!done && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (pc == lEnd[15:0]) done = 1'b1;
        end
        checkOutput($sformatf("div_reach_end %0d/%0d", a, b), done, 1'b1);
        checkOutput($sformatf("div_quot %0d/%0d", a, b), ram[2], q[15:0]);
        checkOutput($sformatf("div_rem %0d/%0d", a, b), ram[3], r[15:0]);
        checkOutput($sformatf("div_keep0 %0d/%0d", a, b), ram[0], a[15:0]);
        checkOutput($sformatf("div_keep1 %0d/%0d", a, b), ram[1], b[15:0]);
        useRom = 1'b0;
    endtask

    initial begin
        int prevPc;
        logic [15:0] rInstr;
        logic [15:0] rM;
        int da, db;

        checkCount = 0;
        passCount  = 0;
        useRom     = 1'b0;
        drvInM     = 16'h0000;
        drvInstr   = cI(C_ONE, D_M, J_NONE);
        rst_n      = 1'b0;
        mA = 0; mD = 0; mPC = 0;

        tblComp[0]  = 7'b0101010; tblExp[0]  = 16'h0000;
        tblComp[1]  = 7'b0111111; tblExp[1]  = 16'h0001;
        tblComp[2]  = 7'b0111010; tblExp[2]  = 16'hFFFF;
        tblComp[3]  = 7'b0001100; tblExp[3]  = 16'h0011;
        tblComp[4]  = 7'b0110000; tblExp[4]  = 16'h0003;
        tblComp[5]  = 7'b0001101; tblExp[5]  = 16'hFFEE;
        tblComp[6]  = 7'b0110001; tblExp[6]  = 16'hFFFC;
        tblComp[7]  = 7'b0001111; tblExp[7]  = 16'hFFEF;
        tblComp[8]  = 7'b0110011; tblExp[8]  = 16'hFFFD;
        tblComp[9]  = 7'b0011111; tblExp[9]  = 16'h0012;
        tblComp[10] = 7'b0110111; tblExp[10] = 16'h0004;
        tblComp[11] = 7'b0001110; tblExp[11] = 16'h0010;
        tblComp[12] = 7'b0110010; tblExp[12] = 16'h0002;
        tblComp[13] = 7'b0000010; tblExp[13] = 16'h0014;
        tblComp[14] = 7'b0010011; tblExp[14] = 16'h000E;
        tblComp[15] = 7'b0000111; tblExp[15] = 16'hFFF2;
        tblComp[16] = 7'b0000000; tblExp[16] = 16'h0001;
        tblComp[17] = 7'b0010101; tblExp[17] = 16'h0013;

        for (int i = 0; i < 65536; i++) begin
            rom[i] = 16'h0000;
            ram[i] = 16'h0000;
        end
        buildDiv();
        buildDiv();

        $display("[TB] reset state");
        #12;
        checkOutput("reset_pc", pc, 16'h0000);
        checkOutput("reset_addrM", addrM, 16'h0000);
        checkOutput("reset_writeM", writeM, 1'b0);
        releaseReset(aI(0));

        $display("[TB] load 0x5555, D=A, M=D+1");
        applyStimulus(aI(16'h5555), 16'h0000);
        checkOutput("load_addrM", addrM, 16'h5555);
        applyStimulus(cI(C_A, D_D, J_NONE), 16'h0000);
        applyStimulus(cI(C_DP1, D_M, J_NONE), 16'h0000);
        checkOutput("store_outM", sampledOut, 16'h5556);
        checkOutput("store_writeM", sampledWr, 1'b1);

        $display("[TB] ALU table");
        applyStimulus(aI(17), 16'h0000);
        applyStimulus(cI(C_A, D_D, J_NONE), 16'h0000);
        applyStimulus(aI(3), 16'h0000);
        for (int i = 0; i < 18; i++) begin
            rM = $urandom;
            applyStimulus(cI(tblComp[i], D_M, J_NONE), rM);
            checkOutput($sformatf("alu_a0_%0d", i), sampledOut, tblExp[i]);
        end
        for (int i = 0; i < 18; i++) begin
            applyStimulus(cI(tblComp[i] | 7'b1000000, D_M, J_NONE), 16'h0003);
            checkOutput($sformatf("alu_a1_%0d", i), sampledOut, tblExp[i]);
        end

        $display("[TB] jumps");
        applyStimulus(cI(C_ZERO, D_D, J_NONE), 16'h0000);
        applyStimulus(aI(100), 16'h0000);
        applyStimulus(cI(C_D, D_NULL, J_JEQ), 16'h0000);
        checkOutput("jeq_taken", pc, 16'd100);
        applyStimulus(aI(16'h7FFF), 16'h0000);
        applyStimulus(cI(C_A, D_D, J_NONE), 16'h0000);
        applyStimulus(cI(C_DP1, D_D, J_NONE), 16'h0000);
        applyStimulus(aI(200), 16'h0000);
        applyStimulus(cI(C_D, D_NULL, J_JLT), 16'h0000);
        checkOutput("jlt_taken", pc, 16'd200);
        applyStimulus(cI(C_ONE, D_D, J_NONE), 16'h0000);
        applyStimulus(aI(300), 16'h0000);
        prevPc = mPC;
        applyStimulus(cI(C_D, D_NULL, J_JLE), 16'h0000);
        checkOutput("jle_not_taken", pc, prevPc + 1);
        applyStimulus(aI(400), 16'h0000);
        applyStimulus(cI(C_ZERO, D_NULL, J_JMP), 16'h0000);
        checkOutput("jmp_taken", pc, 16'd400);
        applyStimulus(cI(C_NEG1, D_A, J_NONE), 16'h0000);
        applyStimulus(cI(C_ZERO, D_NULL, J_JMP), 16'h0000);
        checkOutput("jmp_to_ffff", pc, 16'hFFFF);
        applyStimulus(aI(5), 16'h0000);
        checkOutput("pc_wrap", pc, 16'h0000);
        applyStimulus(aI(77), 16'h0000);
        applyStimulus(cI(C_D, D_A, J_JMP), 16'h0000);
        checkOutput("jump_uses_old_a", pc, 16'd77);

        $display("[TB] random instructions");
        for (int i = 0; i < 400; i++) begin
            rInstr = $urandom;
            rM     = $urandom;
            applyStimulus(rInstr, rM);
        end

        $display("[TB] reset mid-run");
        applyStimulus(aI(16'h2222), 16'h0000);
        applyStimulus(cI(C_A, D_D, J_NONE), 16'h0000);
        @(negedge clk);
        drvInstr = cI(C_D, D_M, J_NONE);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pc", pc, 16'h0000);
        checkOutput("midrst_addrM", addrM, 16'h0000);
        checkOutput("midrst_writeM", writeM, 1'b0);
        checkOutput("midrst_D_cleared", outM, 16'h0000);
        releaseReset(aI(16'h1234));

        $display("[TB] division program");
        runDiv(42, 7);
        runDiv(26, 7);
        runDiv(-7, 2);
        runDiv(7, -2);
        runDiv(-7, -2);
        runDiv(0, 0);
        for (int i = 0; i < 3; i++) begin
            da = int'($urandom_range(0, 600)) - 300;
            db = int'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 1) db = -db;
            runDiv(da, db);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
